// File: rtl/pat_seq_detector_pkg.sv
// rtl/pat_seq_detector_pkg.sv - elaboration-time helpers for the serial pattern detector
package pat_seq_detector_pkg;

    localparam int MAX_PAT_LEN = 16;

    function automatic int state_w(input int len);
        return ($clog2(len) < 1) ? 1 : $clog2(len);
    endfunction

    // Pattern position i (0 = first received) lives at pattern[len-1-i].
    function automatic int border(input logic [MAX_PAT_LEN-1:0] pattern, input int len);
        int  best;
        logic ok;
        best = 0;
        for (int l = 1; l < len; l++) begin
            ok = 1'b1;
            for (int i = 0; i < l; i++) begin
                if (pattern[len-1-i] != pattern[l-1-i]) ok = 1'b0;
            end
            if (ok) best = l;
        end
        return best;
    endfunction

    // Longest proper pattern prefix that is a suffix of (matched k-bit prefix, b).
    function automatic int next_state(input logic [MAX_PAT_LEN-1:0] pattern, input int len,
                                      input int k, input logic b);
        int   best;
        int   j;
        logic ok;
        logic sb;
        best = 0;
        for (int l = 1; l <= k + 1; l++) begin
            if (l < len) begin
                ok = 1'b1;
                for (int i = 0; i < l; i++) begin
                    j  = k + 1 - l + i;
                    sb = (j < k) ? pattern[len-1-j] : b;
                    if (sb != pattern[len-1-i]) ok = 1'b0;
                end
                if (ok) best = l;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/pat_seq_match_counter.sv
// rtl/pat_seq_match_counter.sv - generic saturating event counter
module pat_seq_match_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pat_seq_detector.sv
// rtl/pat_seq_detector.sv - parametrised KMP serial pattern detector with Mealy match flag
// Match counter present only when PAT_SEQ_DETECTOR_COUNT_EN is defined.
module pat_seq_detector
    import pat_seq_detector_pkg::*;
#(
    parameter int               PAT_LEN = 5,
    parameter logic [PAT_LEN-1:0] PATTERN = 5'b10110,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_in,
    input  logic             valid_in,
    output logic             data_out,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int                     SW      = state_w(PAT_LEN);
    localparam logic [MAX_PAT_LEN-1:0] PAT_EXT = MAX_PAT_LEN'(PATTERN);
    localparam logic [SW-1:0]          K_LAST  = SW'(PAT_LEN - 1);
    localparam logic [SW-1:0]          K_BORD  = SW'(border(PAT_EXT, PAT_LEN));

    logic [SW-1:0] k_q;
    logic [SW-1:0] k_d;
    logic          match;
    logic [SW-1:0] adv_tbl [2**SW][2];

    // Unreachable encodings (PAT_LEN not a power of two) fall back to 0.
    for (genvar gk = 0; gk < 2**SW; gk++) begin : g_k
        for (genvar gb = 0; gb < 2; gb++) begin : g_b
            if (gk < PAT_LEN) begin : g_live
                assign adv_tbl[gk][gb] = SW'(next_state(PAT_EXT, PAT_LEN, gk, 1'(gb)));
            end else begin : g_dead
                assign adv_tbl[gk][gb] = '0;
            end
        end
    end

    always_comb begin
        k_d   = k_q;
        match = 1'b0;
        if (valid_in) begin
            match = (k_q == K_LAST) && (data_in == PATTERN[0]);
            if (match) k_d = OVERLAP ? K_BORD : '0;
            else       k_d = adv_tbl[k_q][data_in];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) k_q <= '0;
        else     k_q <= k_d;
    end

    assign data_out = match;

`ifdef PAT_SEQ_DETECTOR_COUNT_EN
    pat_seq_match_counter #(.W(CNT_W)) u_match_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (data_out),
        .count (match_cnt)
    );
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_pat_seq_detector.sv
// tb/tb_pat_seq_detector.sv - randomized and directed bench for pat_seq_detector (honours PAT_SEQ_DETECTOR_COUNT_EN)
module tb_pat_seq_detector;

    localparam int NI = 5;
    localparam int          L    [NI] = '{5, 5, 5, 6, 2};
    localparam logic [15:0] P    [NI] = '{16'b10110, 16'b10110, 16'b10110, 16'b101101, 16'b11};
    localparam bit          O    [NI] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam int          MAXC [NI] = '{255, 255, 3, 255, 255};
`ifdef PAT_SEQ_DETECTOR_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic data_in;
    logic valid_in;

    logic       d_ov, d_no, d_sat, d_alt, d_two;
    logic [7:0] c_ov, c_no, c_alt, c_two;
    logic [1:0] c_sat;
    logic       dout [NI];
    logic [7:0] cnt8 [NI];

    always #5 clk = ~clk;

    pat_seq_detector #(.PAT_LEN(5), .PATTERN(5'b10110), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .data_out(d_ov), .match_cnt(c_ov));
    pat_seq_detector #(.PAT_LEN(5), .PATTERN(5'b10110), .OVERLAP(1'b0), .CNT_W(8)) u_no (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .data_out(d_no), .match_cnt(c_no));
    pat_seq_detector #(.PAT_LEN(5), .PATTERN(5'b10110), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .data_out(d_sat), .match_cnt(c_sat));
    pat_seq_detector #(.PAT_LEN(6), .PATTERN(6'b101101), .OVERLAP(1'b1), .CNT_W(8)) u_alt (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .data_out(d_alt), .match_cnt(c_alt));
    pat_seq_detector #(.PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(8)) u_two (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .data_out(d_two), .match_cnt(c_two));

    assign dout[0] = d_ov;  assign cnt8[0] = c_ov;
    assign dout[1] = d_no;  assign cnt8[1] = c_no;
    assign dout[2] = d_sat; assign cnt8[2] = {6'd0, c_sat};
    assign dout[3] = d_alt; assign cnt8[3] = c_alt;
    assign dout[4] = d_two; assign cnt8[4] = c_two;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lmask(input int n);
        return 16'((32'h1 << n) - 1);
    endfunction

    // Reference: a match is the last L qualified bits equalling the pattern, with
    // at least L bits since reset (overlap) or since the previous match (no overlap).
    bit          chk_en = 1'b0;
    logic [15:0] hist   = '0;
    int          nbits  = 0;
    int          since [NI] = '{default: 0};
    int          cnt_m [NI] = '{default: 0};

    always @(negedge clk) begin
        logic [15:0] h;
        logic        e;
        if (chk_en) begin
            if (rst) begin
                hist  = '0;
                nbits = 0;
                for (int i = 0; i < NI; i++) begin
                    since[i] = 0;
                    cnt_m[i] = 0;
                end
            end
            h = {hist[14:0], data_in};
            for (int i = 0; i < NI; i++) begin
                e = 1'b0;
                if (!rst && valid_in)
                    e = (nbits + 1 >= L[i]) && ((h & lmask(L[i])) == P[i])
                        && (O[i] || (since[i] + 1 >= L[i]));
                check($sformatf("data_out[%0d]", i), int'(dout[i]), int'(e));
                check($sformatf("match_cnt[%0d]", i), int'(cnt8[i]), COUNT_EN ? cnt_m[i] : 0);
                if (!rst && valid_in) begin
                    since[i] = e ? 0 : ((since[i] < 64) ? since[i] + 1 : since[i]);
                    if (e && cnt_m[i] < MAXC[i]) cnt_m[i]++;
                end
            end
            if (!rst && valid_in) begin
                hist = h;
                if (nbits < 64) nbits++;
            end
        end
    end

    int   qbit;
    int   mask [NI];
    bit   gap_pulse;
    bit   prev_sat;
    int   sat_q [$];

    task automatic clear_rec();
        qbit      = 0;
        gap_pulse = 1'b0;
        prev_sat  = 1'b0;
        sat_q.delete();
        for (int i = 0; i < NI; i++) mask[i] = 0;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst = 1'b1;
        valid_in = 1'b0;
        @(negedge clk); #1;
        for (int i = 0; i < NI; i++) begin
            check("reset data_out", int'(dout[i]), 0);
            check("reset match_cnt", int'(cnt8[i]), 0);
        end
        repeat (n - 1) @(posedge clk);
        clear_rec();
    endtask

    task automatic send(input logic b, input logic v);
        @(posedge clk); #1;
        rst = 1'b0;
        data_in = b;
        valid_in = v;
        @(negedge clk); #1;
        if (v) qbit++;
        for (int i = 0; i < NI; i++) begin
            if (dout[i]) begin
                if (v) mask[i] |= (1 << qbit);
                else   gap_pulse = 1'b1;
            end
        end
        if (prev_sat) sat_q.push_back(int'(cnt8[2]));
        prev_sat = dout[2];
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) send(bits[n-1-i], 1'b1);
    endtask

    int pos;
    logic [4:0] seed_pat;

    initial begin
        rst = 1'b1;
        valid_in = 1'b0;
        data_in = 1'b0;
        clear_rec();
        @(posedge clk); #1;
        chk_en = 1'b1;

        do_reset(2);
        send_bits(32'b10110110110, 11);
        check("ovl pulses 5,8,11", mask[0], 32'h920);
        check("novl pulses 5,11", mask[1], 32'h820);
        send(1'b0, 1'b0);
        check("ovl count 3", int'(cnt8[0]), COUNT_EN ? 3 : 0);
        check("novl count 2", int'(cnt8[1]), COUNT_EN ? 2 : 0);

        do_reset(1);
        send_bits(32'b1011, 4);
        for (int i = 0; i < 4; i++) send(1'(i), 1'b0);
        send(1'b0, 1'b1);
        check("gap no pulse", int'(gap_pulse), 0);
        check("gap final pulse", mask[0], 32);

        do_reset(1);
        send_bits(32'b101, 3);
        do_reset(1);
        send_bits(32'b10110, 5);
        check("mid reset discards", mask[0], 32);

        do_reset(1);
        send_bits(32'b1010110, 7);
        check("kmp fallback bit 7", mask[0], 128);

        do_reset(1);
        send_bits(32'b10110110110110110, 17);
        send(1'b0, 1'b0);
        check("sat sample count", sat_q.size(), 5);
        for (int i = 0; i < sat_q.size() && i < 5; i++)
            check($sformatf("sat seq %0d", i), sat_q[i], COUNT_EN ? ((i + 1 < 3) ? i + 1 : 3) : 0);

        do_reset(1);
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 199) == 0);
            data_in = 1'($urandom);
            valid_in = ($urandom_range(0, 3) != 0);
        end
        seed_pat = 5'b10110;
        pos = 0;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 249) == 0);
            valid_in = ($urandom_range(0, 3) != 0);
            data_in = ($urandom_range(0, 9) == 0) ? 1'($urandom) : seed_pat[4 - (pos % 5)];
            if (valid_in) pos++;
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
